// File: rtl/axi4_master_bridge.sv
// AXI4 initiator bridging a simple core request/response port onto AXI4 master channels.
// Single transaction in flight: INCR read bursts or single-beat strobed writes.
module axi4_master_bridge #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [3:0]  AXI_ID = 4'd0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [7:0]            req_len,
    input  logic [2:0]            req_size,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_last,
    output logic                  rsp_err,
    output logic                  proto_err,
    output logic [3:0]            io_master_awid,
    output logic [ADDR_W-1:0]     io_master_awaddr,
    output logic [7:0]            io_master_awlen,
    output logic [2:0]            io_master_awsize,
    output logic [1:0]            io_master_awburst,
    output logic                  io_master_awvalid,
    input  logic                  io_master_awready,
    output logic [DATA_W-1:0]     io_master_wdata,
    output logic [DATA_W/8-1:0]   io_master_wstrb,
    output logic                  io_master_wlast,
    output logic                  io_master_wvalid,
    input  logic                  io_master_wready,
    input  logic [3:0]            io_master_bid,
    input  logic [1:0]            io_master_bresp,
    input  logic                  io_master_bvalid,
    output logic                  io_master_bready,
    output logic [3:0]            io_master_arid,
    output logic [ADDR_W-1:0]     io_master_araddr,
    output logic [7:0]            io_master_arlen,
    output logic [2:0]            io_master_arsize,
    output logic [1:0]            io_master_arburst,
    output logic                  io_master_arvalid,
    input  logic                  io_master_arready,
    input  logic [3:0]            io_master_rid,
    input  logic [DATA_W-1:0]     io_master_rdata,
    input  logic [1:0]            io_master_rresp,
    input  logic                  io_master_rlast,
    input  logic                  io_master_rvalid,
    output logic                  io_master_rready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  proto_err_q, proto_err_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d    = req_addr;
                len_d     = req_len;
                size_d    = req_size;
                wdata_d   = req_wdata;
                wstrb_d   = req_wstrb;
                cnt_d     = '0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = req_wen ? AW_W : AR;
            end
            AR: if (io_master_arready) begin
                cnt_d   = '0;
                state_d = R;
            end
            R: if (io_master_rvalid && rsp_ready) begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                // rlast on the wrong beat, or the expected last beat without rlast, flags the slave
                if (io_master_rlast) begin
                    state_d = IDLE;
                    if (cnt_q != len_q) proto_err_d = 1'b1;
                end else if (cnt_q == len_q) begin
                    proto_err_d = 1'b1;
                end
            end
            AW_W: begin
                if (io_master_awready) aw_done_d = 1'b1;
                if (io_master_wready)  w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = B;
            end
            B: if (io_master_bvalid && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid        = 1'b0;
        rsp_rdata        = '0;
        rsp_last         = 1'b0;
        rsp_err          = 1'b0;
        io_master_rready = 1'b0;
        io_master_bready = 1'b0;
        if (state_q == R) begin
            io_master_rready = rsp_ready;
            rsp_valid        = io_master_rvalid;
            rsp_rdata        = io_master_rdata;
            rsp_last         = io_master_rlast;
            rsp_err          = (io_master_rresp != 2'b00);
        end else if (state_q == B) begin
            io_master_bready = rsp_ready;
            rsp_valid        = io_master_bvalid;
            rsp_last         = 1'b1;
            rsp_err          = (io_master_bresp != 2'b00);
        end
    end

    assign req_ready         = (state_q == IDLE);
    assign proto_err         = proto_err_q;

    assign io_master_arid    = AXI_ID;
    assign io_master_araddr  = addr_q;
    assign io_master_arlen   = len_q;
    assign io_master_arsize  = size_q;
    assign io_master_arburst = 2'b01;
    assign io_master_arvalid = (state_q == AR);

    assign io_master_awid    = AXI_ID;
    assign io_master_awaddr  = addr_q;
    assign io_master_awlen   = 8'd0;
    assign io_master_awsize  = size_q;
    assign io_master_awburst = 2'b01;
    assign io_master_awvalid = (state_q == AW_W) && !aw_done_q;

    assign io_master_wdata   = wdata_q;
    assign io_master_wstrb   = wstrb_q;
    assign io_master_wlast   = 1'b1;
    assign io_master_wvalid  = (state_q == AW_W) && !w_done_q;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Self-checking bench for axi4_master_bridge: directed scenarios plus randomized reads/writes
// against a transaction-level expectation of beats, acks and the sticky protocol-error flag.
module tb_axi4_master_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_last, rsp_err, proto_err;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  wstrb;

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_proto = 1'b0;

    always #5 clock = ~clock;

    axi4_master_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .proto_err(proto_err),
        .io_master_awid(awid), .io_master_awaddr(awaddr), .io_master_awlen(awlen),
        .io_master_awsize(awsize), .io_master_awburst(awburst), .io_master_awvalid(awvalid),
        .io_master_awready(awready), .io_master_wdata(wdata), .io_master_wstrb(wstrb),
        .io_master_wlast(wlast), .io_master_wvalid(wvalid), .io_master_wready(wready),
        .io_master_bid(bid), .io_master_bresp(bresp), .io_master_bvalid(bvalid),
        .io_master_bready(bready), .io_master_arid(arid), .io_master_araddr(araddr),
        .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
        .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_rid(rid),
        .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast),
        .io_master_rvalid(rvalid), .io_master_rready(rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (c % 2) == 0;
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic clear_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rlast = 0; rresp = 0; rdata = 0; rid = 0;
    endtask

    // Presents a request, holds it one accepting edge, then scrambles the request bus.
    task automatic accept(input bit wen, input [31:0] a, input [7:0] l, input [2:0] s,
                          input [31:0] d, input [3:0] st);
        @(negedge clock);
        req_valid = 1; req_wen = wen; req_addr = a; req_len = l; req_size = s;
        req_wdata = d; req_wstrb = st;
        #1;
        check_eq("req_ready_idle", req_ready, 1);
        check_eq("arvalid_at_accept", arvalid, 0);
        check_eq("awvalid_at_accept", awvalid, 0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 0; req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        #1;
        check_eq("req_ready_busy", req_ready, 0);
    endtask

    task automatic do_read(input [31:0] a, input [7:0] l, input [2:0] s, input int ar_delay,
                           input int last_beat, input int mode, input bit allow_err,
                           input int abort_beat);
        logic [31:0] bdata [0:15];
        logic [1:0]  rr    [0:15];
        logic [31:0] got_d [$];
        bit          got_l [$];
        bit          got_e [$];
        bit rv, done;
        int b;
        for (int i = 0; i < 16; i++) begin
            bdata[i] = $urandom;
            rr[i]    = (allow_err && $urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
        end
        if (ar_delay == 2 && l == 0 && a == 32'h3000_0000) bdata[0] = 32'hDEAD_BEEF;
        accept(0, a, l, s, 32'h0, 4'h0);
        check_eq("arvalid_rise", arvalid, 1);
        check_eq("araddr", araddr, a);
        check_eq("arlen", arlen, l);
        check_eq("arsize", arsize, s);
        check_eq("arburst", arburst, 2'b01);
        check_eq("arid", arid, 0);
        for (int c = 0; c <= ar_delay; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            arready = (c == ar_delay);
            check_eq("arvalid_hold", arvalid, 1);
            check_eq("araddr_hold", araddr, a);
            check_eq("rsp_valid_ar", rsp_valid, 0);
            @(posedge clock);
        end
        rv = 0; done = 0; b = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            arready = 0;
            if (b == abort_beat) begin
                reset = 0;
                clear_slave();
                #1;
                check_eq("rst_arvalid", arvalid, 0);
                check_eq("rst_awvalid", awvalid, 0);
                check_eq("rst_wvalid", wvalid, 0);
                check_eq("rst_rsp_valid", rsp_valid, 0);
                check_eq("rst_rready", rready, 0);
                check_eq("rst_proto_err", proto_err, 0);
                @(posedge clock);
                @(negedge clock);
                reset = 1;
                exp_proto = 0;
                #1;
                check_eq("rst_req_ready", req_ready, 1);
                return;
            end
            rsp_ready = rdy(mode, c);
            if (!rv) rv = ($urandom_range(0, 3) != 0);
            rvalid = rv; rdata = bdata[b]; rlast = (b == last_beat); rresp = rr[b];
            rid = 4'($urandom);
            #1;
            check_eq("rready_mirror", rready, rsp_ready);
            check_eq("rsp_valid_r", rsp_valid, rv);
            check_eq("arvalid_in_r", arvalid, 0);
            if (rsp_valid && rsp_ready) begin
                got_d.push_back(rsp_rdata);
                got_l.push_back(rsp_last);
                got_e.push_back(rsp_err);
            end
            if (rv && rready) begin
                if (b == last_beat) done = 1;
                b++;
                rv = 0;
            end
            @(posedge clock);
        end
        if (!done) check_eq("r_timeout", 0, 1);
        if (last_beat != l) exp_proto = 1;
        @(negedge clock);
        clear_slave();
        #1;
        check_eq("req_ready_after_r", req_ready, 1);
        check_eq("proto_err", proto_err, exp_proto);
        check_eq("r_beats", got_d.size(), last_beat + 1);
        for (int i = 0; i < got_d.size() && i <= last_beat; i++) begin
            check_eq("r_data", got_d[i], bdata[i]);
            check_eq("r_last", got_l[i], i == last_beat);
            check_eq("r_err", got_e[i], rr[i] != 0);
        end
    endtask

    task automatic do_write(input [31:0] a, input [31:0] d, input [3:0] st, input [2:0] s,
                            input int aw_delay, input int w_delay, input int b_delay,
                            input [1:0] resp, input int mode);
        bit aw_m, w_m, acked;
        accept(1, a, 8'($urandom), s, d, st);
        check_eq("awvalid_rise", awvalid, 1);
        check_eq("wvalid_rise", wvalid, 1);
        check_eq("awaddr", awaddr, a);
        check_eq("awlen", awlen, 0);
        check_eq("awsize", awsize, s);
        check_eq("awburst", awburst, 2'b01);
        check_eq("awid", awid, 0);
        check_eq("wdata", wdata, d);
        check_eq("wstrb", wstrb, st);
        check_eq("wlast", wlast, 1);
        aw_m = 0; w_m = 0;
        for (int c = 0; c < 100 && !(aw_m && w_m); c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            awready = (c >= aw_delay);
            wready  = (c >= w_delay);
            check_eq("awvalid_hold", awvalid, !aw_m);
            check_eq("wvalid_hold", wvalid, !w_m);
            check_eq("rsp_valid_aw", rsp_valid, 0);
            check_eq("bready_aw", bready, 0);
            @(posedge clock);
            if (awready) aw_m = 1;
            if (wready)  w_m = 1;
        end
        if (!(aw_m && w_m)) check_eq("aw_w_timeout", 0, 1);
        acked = 0;
        for (int c = 0; c < 200 && !acked; c++) begin
            @(negedge clock);
            awready = 0; wready = 0;
            bvalid = (c >= b_delay); bresp = resp; bid = 4'($urandom);
            rsp_ready = rdy(mode, c);
            #1;
            check_eq("bready_mirror", bready, rsp_ready);
            check_eq("rsp_valid_b", rsp_valid, bvalid);
            check_eq("awvalid_in_b", awvalid, 0);
            check_eq("wvalid_in_b", wvalid, 0);
            if (rsp_valid && rsp_ready) begin
                check_eq("b_last", rsp_last, 1);
                check_eq("b_rdata", rsp_rdata, 0);
                check_eq("b_err", rsp_err, resp != 0);
                acked = 1;
            end
            @(posedge clock);
        end
        if (!acked) check_eq("b_timeout", 0, 1);
        @(negedge clock);
        clear_slave();
        #1;
        check_eq("req_ready_after_b", req_ready, 1);
    endtask

    initial begin
        reset = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_len = 0; req_size = 0;
        req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        clear_slave();
        #12;
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_arvalid", arvalid, 0);
        check_eq("reset_awvalid", awvalid, 0);
        check_eq("reset_wvalid", wvalid, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_proto_err", proto_err, 0);
        @(negedge clock);
        reset = 1;

        do_read(32'h3000_0000, 8'd0, 3'd2, 2, 0, 0, 0, -1);
        do_read(32'hA000_0010, 8'd3, 3'd2, 0, 3, 1, 0, -1);
        do_write(32'hA000_0004, 32'h1234_5678, 4'b0011, 3'd2, 3, 0, 1, 2'b00, 0);
        do_write(32'hA000_0008, 32'hCAFE_F00D, 4'b1111, 3'd2, 0, 0, 2, 2'b10, 1);
        do_read(32'hA000_0020, 8'd1, 3'd2, 1, 1, 0, 0, -1);
        do_read(32'hA000_0040, 8'd3, 3'd2, 0, 1, 0, 0, -1);
        do_read(32'hA000_0080, 8'd0, 3'd2, 0, 0, 2, 0, -1);
        do_read(32'hA000_0100, 8'd3, 3'd2, 0, 3, 0, 0, 1);
        do_read(32'hA000_0200, 8'd0, 3'd2, 1, 0, 0, 0, -1);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_write($urandom, $urandom, 4'($urandom), 3'($urandom_range(0, 2)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00, $urandom_range(0, 2));
            end else begin
                int l, r, lb;
                l  = $urandom_range(0, 7);
                r  = $urandom_range(0, 7);
                lb = (r == 0 && l > 0) ? l - 1 : (r == 1 ? l + 1 : l);
                do_read($urandom, 8'(l), 3'($urandom_range(0, 2)), $urandom_range(0, 3),
                        lb, $urandom_range(0, 2), 1, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
